// File: rtl/countdown_timer_if.sv
// Control/status bundle between a countdown_timer and whatever drives it.
// The master loads and starts the timer; the slave (the timer) reports time and status.
interface countdown_timer_if;
  logic        load;
  logic [15:0] load_value;
  logic        start;
  logic [15:0] count;
  logic        running;
  logic        done;
  logic        expire;

  modport master (
    output load, load_value, start,
    input  count, running, done, expire
  );

  modport slave (
    input  load, load_value, start,
    output count, running, done, expire
  );
endinterface

// File: rtl/countdown_timer.sv
// Four-digit BCD MM:SS countdown timer with an integrated tick prescaler.
// Loads a clamped preset, decrements once per TICK_DIV clocks, and flags expiry at 00:00.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 524288
) (
  input  logic             clock,
  input  logic             reset,
  countdown_timer_if.slave bus
);

  localparam int unsigned     PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]   PRESC_ZERO = {PW{1'b0}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          expire_q, expire_d;

  logic          tick;
  logic [15:0]   count_dec;
  logic [15:0]   load_clamped;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_d);
    return (d > max_d) ? max_d : d;
  endfunction

  function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
    return {clamp_digit(v[15:12], 4'd5), clamp_digit(v[11:8], 4'd9),
            clamp_digit(v[7:4], 4'd5),   clamp_digit(v[3:0], 4'd9)};
  endfunction

  // One-second BCD decrement with borrow through ss and mm digit pairs.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (v[11:8] != 4'd0) begin
          r[11:8] = v[11:8] - 4'd1;
        end else begin
          r[11:8] = 4'd9;
          r[15:12] = (v[15:12] != 4'd0) ? (v[15:12] - 4'd1) : 4'd0;
        end
      end
    end
    return r;
  endfunction

  assign tick         = (state_q == RUN) && (presc_q == PRESC_LAST);
  assign count_dec    = bcd_dec(count_q);
  assign load_clamped = clamp_bcd(bus.load_value);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= 16'h0000;
      presc_q   <= PRESC_ZERO;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expire_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      done_q    <= done_d;
      expire_q  <= expire_d;
    end
  end

  // Expiry outranks a same-cycle pause so RUN can never hold 00:00.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          state_d = IDLE;
        end else if (bus.start && (count_q != 16'h0000)) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (tick && (count_dec == 16'h0000)) begin
          state_d = DONE;
        end else if (bus.start) begin
          state_d = PAUSED;
        end else begin
          state_d = RUN;
        end
      end
      PAUSED: begin
        if (bus.load) begin
          state_d = IDLE;
        end else if (bus.start) begin
          state_d = RUN;
        end else begin
          state_d = PAUSED;
        end
      end
      DONE: begin
        if (bus.load) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    presc_d  = presc_q;
    expire_d = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d = PRESC_ZERO;
        if (bus.load) begin
          count_d = load_clamped;
        end else begin
          count_d = count_q;
        end
      end
      RUN: begin
        // The prescaler keeps advancing on a pause cycle; only PAUSED freezes it.
        if (tick) begin
          presc_d  = PRESC_ZERO;
          count_d  = count_dec;
          expire_d = (count_dec == 16'h0000);
        end else begin
          presc_d  = presc_q + PW'(1);
          count_d  = count_q;
        end
      end
      PAUSED: begin
        if (bus.load) begin
          count_d = load_clamped;
          presc_d = PRESC_ZERO;
        end else begin
          count_d = count_q;
          presc_d = presc_q;
        end
      end
      DONE: begin
        presc_d = PRESC_ZERO;
        if (bus.load) begin
          count_d = load_clamped;
        end else begin
          count_d = 16'h0000;
        end
      end
      default: begin
        count_d = 16'h0000;
        presc_d = PRESC_ZERO;
      end
    endcase
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  assign bus.count   = count_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.expire  = expire_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a seconds-based reference model.
module tb_countdown_timer;

  localparam int TICK_DIV = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  countdown_timer_if bus ();

  countdown_timer #(.TICK_DIV(TICK_DIV)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit          l;
    logic [15:0] lv;
    bit          s;
    logic [15:0] ec;
    bit          er;
    bit          ed;
    bit          ee;
  } vec_t;

  vec_t vecs[$];

  // Reference model: time held as plain seconds, prescaler as a phase counter.
  int m_state, m_secs, m_phase;
  bit m_expire;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
  endtask

  function automatic int clamp_secs(input logic [15:0] v);
    int mt, mo, st, so;
    mt = (v[15:12] > 4'd5) ? 5 : int'(v[15:12]);
    mo = (v[11:8]  > 4'd9) ? 9 : int'(v[11:8]);
    st = (v[7:4]   > 4'd5) ? 5 : int'(v[7:4]);
    so = (v[3:0]   > 4'd9) ? 9 : int'(v[3:0]);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  function automatic logic [15:0] secs_to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_secs = 0; m_phase = 0; m_expire = 1'b0;
  endtask

  task automatic model_step(input bit l, input logic [15:0] lv, input bit s);
    bit t;
    m_expire = 1'b0;
    case (m_state)
      S_IDLE: begin
        if (l) m_secs = clamp_secs(lv);
        else if (s && m_secs != 0) begin m_state = S_RUN; m_phase = 0; end
      end
      S_RUN: begin
        t = (m_phase == TICK_DIV - 1);
        m_phase = (m_phase + 1) % TICK_DIV;
        if (t) m_secs = m_secs - 1;
        if (t && m_secs == 0) begin m_state = S_DONE; m_expire = 1'b1; end
        else if (s) m_state = S_PAUSED;
      end
      S_PAUSED: begin
        if (l) begin m_secs = clamp_secs(lv); m_state = S_IDLE; m_phase = 0; end
        else if (s) m_state = S_RUN;
      end
      S_DONE: begin
        if (l) begin m_secs = clamp_secs(lv); m_state = S_IDLE; m_phase = 0; end
      end
      default: m_state = S_IDLE;
    endcase
  endtask

  task automatic cycle(input bit l, input logic [15:0] lv, input bit s);
    bus.load = l; bus.load_value = lv; bus.start = s;
    @(posedge clock); #1;
    bus.load = 1'b0; bus.start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    model_reset();
  endtask

  function automatic logic [31:0] outs();
    return {13'd0, bus.count, bus.running, bus.done, bus.expire};
  endfunction

  function automatic logic [31:0] exp_outs(input logic [15:0] c, input bit r, input bit d, input bit e);
    return {13'd0, c, r, d, e};
  endfunction

  function automatic void add(input bit l, input logic [15:0] lv, input bit s,
                              input logic [15:0] ec, input bit er, input bit ed, input bit ee);
    vec_t v;
    v.l = l; v.lv = lv; v.s = s; v.ec = ec; v.er = er; v.ed = ed; v.ee = ee;
    vecs.push_back(v);
  endfunction

  initial begin
    bit          l, s;
    logic [15:0] lv;

    reset = 1'b0; bus.load = 1'b0; bus.load_value = 16'h0000; bus.start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", outs(), exp_outs(16'h0000, 1'b0, 1'b0, 1'b0));
    reset = 1'b1;

    // Vector table: each row is one clock, outputs observed after that edge.
    add(1'b1, 16'h7A9F, 1'b0, 16'h5959, 1'b0, 1'b0, 1'b0);
    add(1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    add(1'b1, 16'h0012, 1'b0, 16'h0012, 1'b0, 1'b0, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 16'h0012, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 16'h0000, 1'b0, 16'h0012, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) add(1'b0, 16'h0000, 1'b0, 16'h0011, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) add(1'b0, 16'h0000, 1'b0, 16'h0010, 1'b1, 1'b0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 16'h0009, 1'b1, 1'b0, 1'b0);
    add(1'b1, 16'h1234, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 16'h0009, 1'b0, 1'b0, 1'b0);
    add(1'b1, 16'h0002, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) add(1'b0, 16'h0000, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    add(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
    add(1'b1, 16'h0005, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
    add(1'b1, 16'h0100, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      cycle(vecs[i].l, vecs[i].lv, vecs[i].s);
      check($sformatf("vec[%0d]", i), outs(),
            exp_outs(vecs[i].ec, vecs[i].er, vecs[i].ed, vecs[i].ee));
    end

    // Async reset mid-RUN takes effect between edges.
    do_reset();
    cycle(1'b1, 16'h0130, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1);
    repeat (10) cycle(1'b0, 16'h0000, 1'b0);
    check("midrun_before_reset", outs(), exp_outs(16'h0128, 1'b1, 1'b0, 1'b0));
    #3 reset = 1'b0;
    #1 check("async_reset", outs(), exp_outs(16'h0000, 1'b0, 1'b0, 1'b0));
    @(posedge clock); #1;
    reset = 1'b1;

    // Multi-digit borrow 10:00 -> 09:59.
    cycle(1'b1, 16'h1000, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1);
    repeat (3) cycle(1'b0, 16'h0000, 1'b0);
    check("borrow_pre", {16'd0, bus.count}, 32'h0000_1000);
    cycle(1'b0, 16'h0000, 1'b0);
    check("borrow_1000", {16'd0, bus.count}, 32'h0000_0959);

    // Expiry then DONE is sticky until a load.
    do_reset();
    cycle(1'b1, 16'h0002, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1);
    repeat (8) cycle(1'b0, 16'h0000, 1'b0);
    check("expire", outs(), exp_outs(16'h0000, 1'b0, 1'b1, 1'b1));
    for (int i = 0; i < 50; i++) begin
      cycle(1'b0, 16'h0000, (i % 5) == 0);
      check($sformatf("done_hold[%0d]", i), outs(), exp_outs(16'h0000, 1'b0, 1'b1, 1'b0));
    end
    cycle(1'b1, 16'h0005, 1'b0);
    check("done_reload", outs(), exp_outs(16'h0005, 1'b0, 1'b0, 1'b0));

    // Pause at prescaler 2, resume finishes the tick two clocks later.
    cycle(1'b0, 16'h0000, 1'b1);
    repeat (5) cycle(1'b0, 16'h0000, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1);
    check("pause", outs(), exp_outs(16'h0004, 1'b0, 1'b0, 1'b0));
    repeat (20) cycle(1'b0, 16'h0000, 1'b0);
    check("pause_hold", outs(), exp_outs(16'h0004, 1'b0, 1'b0, 1'b0));
    cycle(1'b0, 16'h0000, 1'b1);
    check("resume", outs(), exp_outs(16'h0004, 1'b1, 1'b0, 1'b0));
    cycle(1'b0, 16'h0000, 1'b0);
    check("resume+1", {16'd0, bus.count}, 32'h0000_0004);
    cycle(1'b0, 16'h0000, 1'b0);
    check("resume+2", {16'd0, bus.count}, 32'h0000_0003);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      l = ($urandom_range(0, 15) == 0);
      s = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 1) == 0) lv = 16'($urandom);
      else lv = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
      cycle(l, lv, s);
      model_step(l, lv, s);
      check($sformatf("rand[%0d]", i), outs(),
            exp_outs(secs_to_bcd(m_secs), m_state == S_RUN, m_state == S_DONE, m_expire));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
